// File: rtl/alu_flopr_mux2_if.sv
// Bundles the ALU, 2:1 mux and PC register signals of alu_flopr_mux2.
// The master drives operands/selects/next value; the slave returns results.
interface alu_flopr_mux2_if #(
    parameter int WIDTH = 32
);
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [2:0]       alu_f;
    logic             alu_cout;
    logic             alu_zero;
    logic [31:0]      alu_y;
    logic [WIDTH-1:0] mux_d0;
    logic [WIDTH-1:0] mux_d1;
    logic             mux_s;
    logic [WIDTH-1:0] mux_y;
    logic [WIDTH-1:0] flop_d;
    logic [WIDTH-1:0] flop_q;

    modport master (
        output alu_a, alu_b, alu_f, mux_d0, mux_d1, mux_s, flop_d,
        input  alu_cout, alu_zero, alu_y, mux_y, flop_q
    );

    modport slave (
        input  alu_a, alu_b, alu_f, mux_d0, mux_d1, mux_s, flop_d,
        output alu_cout, alu_zero, alu_y, mux_y, flop_q
    );
endinterface

// File: rtl/alu_flopr_mux2.sv
// Single-cycle MIPS datapath primitives: 32-bit ALU, resettable PC register
// and 2:1 word mux, wrapped by a thin top that exposes each one independently.

module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  f,
    output logic        cout,
    output logic        zero,
    output logic [31:0] y
);
    logic [31:0] bb_s;
    logic [32:0] sum_s;
    logic        ovf_s;
    logic        lt_s;
    logic [31:0] y_s;

    // Shared adder feeds ADD/SUB/SLT; f[2] inverts b and supplies the +1 of two's complement.
    always_comb begin
        bb_s  = f[2] ? ~b : b;
        sum_s = {1'b0, a} + {1'b0, bb_s} + {32'd0, f[2]};
        ovf_s = (a[31] == bb_s[31]) & (sum_s[31] != a[31]);
        lt_s  = sum_s[31] ^ ovf_s;
        case (f[1:0])
            2'b00:   y_s = a & bb_s;
            2'b01:   y_s = a | bb_s;
            2'b10:   y_s = sum_s[31:0];
            2'b11:   y_s = {31'd0, lt_s};
            default: y_s = 32'd0;
        endcase
    end

    assign y    = y_s;
    assign zero = (y_s == 32'd0);
    assign cout = sum_s[32];
endmodule

module flopr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // PC register; reset wins over d and only takes effect on a clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= {WIDTH{1'b0}};
        end else begin
            q <= d;
        end
    end
endmodule

module mux2 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    assign y = s ? d1 : d0;
endmodule

module alu_flopr_mux2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    alu_flopr_mux2_if.slave  bus
);
    alu u_alu (
        .a    (bus.alu_a),
        .b    (bus.alu_b),
        .f    (bus.alu_f),
        .cout (bus.alu_cout),
        .zero (bus.alu_zero),
        .y    (bus.alu_y)
    );

    flopr #(.WIDTH(WIDTH)) u_flopr (
        .clk   (clk),
        .reset (reset),
        .d     (bus.flop_d),
        .q     (bus.flop_q)
    );

    mux2 #(.WIDTH(WIDTH)) u_mux2 (
        .d0 (bus.mux_d0),
        .d1 (bus.mux_d1),
        .s  (bus.mux_s),
        .y  (bus.mux_y)
    );
endmodule

// File: tb/tb_alu_flopr_mux2.sv
// Scoreboard bench for alu_flopr_mux2: the driver pushes expected results per
// cycle, the monitor pops and compares them on the falling edge.
module tb_alu_flopr_mux2;
    localparam int WIDTH  = 32;
    localparam int NDIR   = 10;
    localparam int NRAND  = 300;

    typedef struct {
        int          idx;
        logic [31:0] y;
        logic        cout;
        logic        zero;
        logic [31:0] my;
        logic        chkq;
        logic [31:0] q;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks_r = 0;
    int   fails_r  = 0;
    exp_t exp_q[$];

    alu_flopr_mux2_if #(.WIDTH(WIDTH)) bus ();

    alu_flopr_mux2 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model from arithmetic rules: signed 64-bit sum gives SLT sign, unsigned gives carry.
    function automatic exp_t ref_model(input int idx, input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] f, input logic [31:0] d0,
                                       input logic [31:0] d1, input logic s);
        exp_t            e;
        logic [31:0]     bb;
        longint unsigned us;
        longint          ss;
        bb = f[2] ? ~b : b;
        us = {32'd0, a} + {32'd0, bb} + {63'd0, f[2]};
        ss = longint'($signed(a)) + longint'($signed(bb)) + longint'({63'd0, f[2]});
        case (f[1:0])
            2'b00:   e.y = a & bb;
            2'b01:   e.y = a | bb;
            2'b10:   e.y = us[31:0];
            default: e.y = (ss < 64'sd0) ? 32'd1 : 32'd0;
        endcase
        e.idx  = idx;
        e.cout = us[32];
        e.zero = (e.y == 32'd0);
        e.my   = s ? d1 : d0;
        e.chkq = 1'b0;
        e.q    = 32'd0;
        return e;
    endfunction

    task automatic check32(input string name, input int idx, input logic [31:0] got,
                           input logic [31:0] want);
        checks_r++;
        if (got !== want) begin
            fails_r++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, want);
        end
    endtask

    // Monitor: every falling edge with a pending expectation is compared.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check32("alu_y", e.idx, bus.alu_y, e.y);
            check32("alu_cout", e.idx, {31'd0, bus.alu_cout}, {31'd0, e.cout});
            check32("alu_zero", e.idx, {31'd0, bus.alu_zero}, {31'd0, e.zero});
            check32("mux_y", e.idx, bus.mux_y, e.my);
            if (e.chkq) begin
                check32("flop_q", e.idx, bus.flop_q, e.q);
            end
        end
    end

    initial begin
        logic [31:0] dir_a [NDIR];
        logic [31:0] dir_b [NDIR];
        logic [2:0]  dir_f [NDIR];
        logic        dir_rst [5];
        logic [31:0] dir_d [5];
        logic        prev_valid;
        logic        prev_rst;
        logic [31:0] prev_d;
        logic [31:0] a, b, d0, d1, d;
        logic [2:0]  f;
        logic        s, rst;
        exp_t        e;
        int          budget;

        dir_a = '{32'd5, 32'd5, 32'd7, 32'hFFFFFFFF, 32'h0000F0F0, 32'h0000F0F0,
                  32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h12345678};
        dir_b = '{32'd3, 32'd3, 32'd7, 32'd1, 32'h00000FF0, 32'h00000FF0,
                  32'd1, 32'h80000000, 32'd1, 32'h0F0F0F0F};
        dir_f = '{3'b010, 3'b110, 3'b110, 3'b010, 3'b000, 3'b001,
                  3'b111, 3'b111, 3'b111, 3'b100};
        dir_rst = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        dir_d   = '{32'h4, 32'h4, 32'h8, 32'hC, 32'h10};

        reset      = 1'b0;
        prev_valid = 1'b0;
        prev_rst   = 1'b0;
        prev_d     = 32'd0;

        for (int i = 0; i < NDIR + NRAND; i++) begin
            @(posedge clk);
            #1;
            if (i < NDIR) begin
                a = dir_a[i];
                b = dir_b[i];
                f = dir_f[i];
            end else begin
                a = $urandom();
                b = (($urandom_range(0, 7)) == 0) ? a : $urandom();
                f = 3'($urandom_range(0, 7));
            end
            if (i < 2) begin
                d0 = 32'hAAAA5555;
                d1 = 32'h12345678;
                s  = (i == 1);
            end else begin
                d0 = $urandom();
                d1 = $urandom();
                s  = 1'($urandom_range(0, 1));
            end
            if (i < 5) begin
                rst = dir_rst[i];
                d   = dir_d[i];
            end else begin
                rst = ($urandom_range(0, 9) == 0);
                d   = $urandom();
            end

            bus.alu_a  = a;
            bus.alu_b  = b;
            bus.alu_f  = f;
            bus.mux_d0 = d0;
            bus.mux_d1 = d1;
            bus.mux_s  = s;
            bus.flop_d = d;
            reset      = rst;

            e = ref_model(i, a, b, f, d0, d1, s);
            e.chkq = prev_valid;
            e.q    = prev_rst ? 32'd0 : prev_d;
            exp_q.push_back(e);

            prev_valid = 1'b1;
            prev_rst   = rst;
            prev_d     = d;
        end

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(posedge clk);
        checks_r++;
        if (exp_q.size() != 0) begin
            fails_r++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks_r, fails_r);
        $finish;
    end
endmodule
